rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Shares the single unified instruction/data memory between two requesters: the instruction-fetch port and the load/store port of the rv32i core.
- Arbitrates with two-way round-robin and sequences one memory transaction at a time over a req/ack handshake.
- Performs the physical address range check and raises an access fault without touching memory.
- Bounds every transaction with a timeout.
- Sits between the core (fetch and LSU) and the memory model/controller.

Parameters:
- MEM_BASE, 32'h8000_0000, first valid byte address.
- MEM_SIZE, 32'h0080_0000, size of the valid window in bytes.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before the arbiter forces an error response; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch address; held until if_gnt
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch response strobe
- if_rdata  out  32  fetch data; valid with if_rvalid
- if_err  out  1  fetch access fault or timeout; valid with if_rvalid
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  store byte enables
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  one-cycle load/store response strobe
- ls_rdata  out  32  load data (0 for stores)
- ls_err  out  1  load/store access fault or timeout
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables (4'hF for reads)
- mem_addr  out  32  memory address, word-aligned ({addr[31:2],2'b00})
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completion, single-cycle
- mem_rdata  in  32  memory read data, valid with mem_ack

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = IF; timeout counter 0.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - gnt is combinational and asserted only in IDLE, to at most one requester.
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant. The first conflict after reset goes to LS.
  - On gnt, latch owner, we, be, addr and wdata, then update last_grant.
  - In range (MEM_BASE <= addr < MEM_BASE+MEM_SIZE, unsigned): go to WAIT.
  - Out of range: set err_q, go directly to RESP, no mem_req.
- WAIT:
  - mem_req=1 with the latched fields held stable.
  - Counter increments each cycle.
  - mem_ack: capture mem_rdata (loads/fetch) or 0 (stores), go to RESP.
  - Counter reaches TIMEOUT_CYCLES without ack: drop mem_req, set err_q, go to RESP.
  - mem_ack on the same cycle as the timeout: the ack wins, no error.
- RESP:
  - Owner's rvalid=1 for exactly one cycle, with rdata and err.
  - On error, rdata = 0.
  - The other requester's rvalid stays 0. Return to IDLE.
- Timing:
  - Zero-wait memory: gnt at t, mem_req at t+1 (ack at t+1), rvalid at t+2, next gnt earliest t+3.
  - Fault: gnt t, rvalid+err t+1.
- mem_ack outside WAIT, including a late ack after a timeout, is ignored.
- The arbiter does not check alignment; misaligned accesses are trapped in the core. The address is truncated to the word and be is passed through unchanged.
- mem_req deasserts the cycle after mem_ack.
- Asynchronous reset mid-transaction drops mem_req immediately. No rvalid is produced for the aborted transaction.

Decomposition:
- Package rv32i_mem_pkg:
  - state enum arb_state_e {IDLE, WAIT, RESP}
  - owner enum {OWN_IF, OWN_LS}
  - mem_req_t struct {we, be, addr, wdata}
  - MEM_BASE/MEM_SIZE defaults
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt[1:0].
  - Combinational; last_grant register stays in the parent.

Test Plan:
- if_req alone, addr 32'h8000_0004, mem_ack 1 cycle after mem_req with rdata 32'h0000_0013 -> if_gnt t0, mem_addr 32'h8000_0004 at t1, if_rvalid t2 with if_rdata 32'h13 and if_err 0.
- Both requests on the first cycle after reset, then both held -> ls granted first, if granted at the next IDLE. Sustained dual requests alternate LS, IF, LS, IF.
- ls store, addr 32'h8000_0102, be 4'b1100, wdata 32'hDEAD_BEEF -> mem_we 1, mem_addr 32'h8000_0100, mem_be 4'b1100, ls_rvalid with ls_rdata 0.
- ls load at 32'h7FFF_FFFC and fetch at 32'h8080_0000 -> err=1 one cycle after gnt, mem_req never asserted.
- mem_ack withheld, TIMEOUT_CYCLES=4 -> mem_req drops after 4 WAIT cycles, rvalid+err. An ack arriving 2 cycles later is ignored and the next grant proceeds normally.
- Assert rst_n low during WAIT -> mem_req 0 immediately, no rvalid. After release, first conflict goes to LS.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared types and defaults for the rv32i unified-memory arbiter.
// The window check is written as an offset compare so MEM_BASE+MEM_SIZE never overflows.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [31:0] DEF_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_SIZE = 32'h0080_0000;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the
// requester that was not granted last. Index 0 is fetch, index 1 is load/store.
module rr_arb2
  import rv32i_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pick
      localparam owner_e ME = (gi == 0) ? OWN_IF : OWN_LS;
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last != ME));
    end
  endgenerate

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory between instruction fetch and load/store: round-robin grant,
// address window check, one transaction at a time, bounded by a timeout.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE       = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE       = DEF_MEM_SIZE,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_reg;
  owner_e        owner_reg;
  owner_e        last_grant_reg;
  mem_req_t      req_reg;
  logic [CW-1:0] cnt_reg;
  logic          mem_req_reg;
  logic          if_rvalid_reg, ls_rvalid_reg;
  logic          if_err_reg, ls_err_reg;
  logic [31:0]   if_rdata_reg, ls_rdata_reg;

  logic [1:0]  req_vec, gnt_vec;
  owner_e      grant_owner;
  mem_req_t    sel_req;
  logic        grant_in_range;
  logic        timeout_hit;
  logic        resp_fire, resp_err;
  logic [31:0] resp_data;
  owner_e      resp_owner;

  // Requests are only visible to the picker in IDLE, which keeps gnt IDLE-only.
  assign req_vec = (state_reg == IDLE) ? {ls_req, if_req} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req  (req_vec),
    .last (last_grant_reg),
    .gnt  (gnt_vec)
  );

  assign if_gnt      = gnt_vec[0];
  assign ls_gnt      = gnt_vec[1];
  assign grant_owner = gnt_vec[1] ? OWN_LS : OWN_IF;

  always_comb begin
    sel_req        = '{we: 1'b0, be: 4'hF, addr: {if_addr[31:2], 2'b00}, wdata: 32'h0};
    grant_in_range = addr_in_range(if_addr, MEM_BASE, MEM_SIZE);
    if (gnt_vec[1]) begin
      sel_req        = '{we: ls_we, be: ls_be, addr: {ls_addr[31:2], 2'b00}, wdata: ls_wdata};
      grant_in_range = addr_in_range(ls_addr, MEM_BASE, MEM_SIZE);
    end
  end

  assign timeout_hit = (cnt_reg == CNT_LAST);

  // A response is produced either by an immediate range fault or by leaving WAIT;
  // an ack on the timeout cycle takes priority over the timeout.
  always_comb begin
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = 32'h0;
    resp_owner = owner_reg;
    case (state_reg)
      IDLE: begin
        resp_owner = grant_owner;
        if ((|gnt_vec) && !grant_in_range) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          resp_fire = 1'b1;
          resp_data = req_reg.we ? 32'h0 : mem_rdata;
        end else if (timeout_hit) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      last_grant_reg <= OWN_IF;
      req_reg        <= '0;
      cnt_reg        <= '0;
      mem_req_reg    <= 1'b0;
      if_rvalid_reg  <= 1'b0;
      ls_rvalid_reg  <= 1'b0;
      if_err_reg     <= 1'b0;
      ls_err_reg     <= 1'b0;
      if_rdata_reg   <= 32'h0;
      ls_rdata_reg   <= 32'h0;
    end else begin
      if_rvalid_reg <= resp_fire && (resp_owner == OWN_IF);
      ls_rvalid_reg <= resp_fire && (resp_owner == OWN_LS);
      if_err_reg    <= resp_fire && (resp_owner == OWN_IF) && resp_err;
      ls_err_reg    <= resp_fire && (resp_owner == OWN_LS) && resp_err;
      if_rdata_reg  <= (resp_fire && (resp_owner == OWN_IF)) ? resp_data : 32'h0;
      ls_rdata_reg  <= (resp_fire && (resp_owner == OWN_LS)) ? resp_data : 32'h0;

      case (state_reg)
        IDLE: begin
          if (|gnt_vec) begin
            owner_reg      <= grant_owner;
            last_grant_reg <= grant_owner;
            req_reg        <= sel_req;
            cnt_reg        <= '0;
            if (grant_in_range) begin
              state_reg   <= WAIT;
              mem_req_reg <= 1'b1;
            end else begin
              state_reg <= RESP;
            end
          end
        end
        WAIT: begin
          if (mem_ack || timeout_hit) begin
            mem_req_reg <= 1'b0;
            state_reg   <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = req_reg.we;
  assign mem_be    = req_reg.be;
  assign mem_addr  = req_reg.addr;
  assign mem_wdata = req_reg.wdata;

  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign if_err    = if_err_reg;
  assign ls_rvalid = ls_rvalid_reg;
  assign ls_rdata  = ls_rdata_reg;
  assign ls_err    = ls_err_reg;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter; inputs change and outputs are sampled
// around the falling edge, one line printed per transaction.
module tb_rv32i_mem_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  rv32i_mem_arbiter #(
    .MEM_BASE       (32'h8000_0000),
    .MEM_SIZE       (32'h0080_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++;
    if ({if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we});
    end
    vectors++;
    if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be} !== 132'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", {if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be});
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({if_gnt, ls_gnt, mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_no_req: got %b expected 000", {if_gnt, ls_gnt, mem_req});
    end
    $display("reset released");
  endtask

  // Both requesters held continuously; zero-wait memory. Expected order LS, IF, LS, IF.
  task automatic test_conflict();
    logic [3:0]  exp_ls;
    logic [31:0] exp_addr, rd;
    exp_ls = 4'b0101;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8000_0010;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h8000_0021; ls_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if ({ls_gnt, if_gnt} !== (exp_ls[i] ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL conflict_gnt[%0d]: got ls,if=%b expected %b", i, {ls_gnt, if_gnt},
                 exp_ls[i] ? 2'b10 : 2'b01);
      end
      exp_addr = exp_ls[i] ? 32'h8000_0020 : 32'h8000_0010;
      rd = 32'hA000_0000 + i;
      @(negedge clk); #1;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL conflict_mem[%0d]: got req=%b addr=%h expected 1 %h", i, mem_req, mem_addr, exp_addr);
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk); #1;
      mem_ack = 1'b0;
      vectors++;
      if (exp_ls[i] ? ({ls_rvalid, if_rvalid, ls_rdata} !== {2'b10, rd})
                    : ({ls_rvalid, if_rvalid, if_rdata} !== {2'b01, rd})) begin
        miscompares++;
        $display("FAIL conflict_resp[%0d]: got ls_rv=%b if_rv=%b if_rd=%h ls_rd=%h expected owner_ls=%b data %h",
                 i, ls_rvalid, if_rvalid, if_rdata, ls_rdata, exp_ls[i], rd);
      end
      $display("conflict txn %0d owner=%s data=%h", i, exp_ls[i] ? "LS" : "IF", rd);
      @(negedge clk);
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8000_0004;
    #1;
    vectors++;
    if ({if_gnt, ls_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL fetch_gnt: got if,ls=%b expected 10", {if_gnt, ls_gnt});
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'hF, 32'h8000_0004}) begin
      miscompares++;
      $display("FAIL fetch_mem: got req=%b we=%b be=%h addr=%h expected 1 0 f 80000004",
               mem_req, mem_we, mem_be, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({if_rvalid, if_err, ls_rvalid, mem_req, if_rdata} !== {4'b1000, 32'h13}) begin
      miscompares++;
      $display("FAIL fetch_resp: got rv=%b err=%b ls_rv=%b mreq=%b data=%h expected 1 0 0 0 00000013",
               if_rvalid, if_err, ls_rvalid, mem_req, if_rdata);
    end
    @(negedge clk); #1;
    vectors++;
    if (if_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_rvalid_pulse: got %b expected 0", if_rvalid);
    end
    $display("fetch addr=80000004 data=%h err=%b", 32'h13, 1'b0);
  endtask

  task automatic test_store();
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b1100; ls_addr = 32'h8000_0102; ls_wdata = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if ({ls_gnt, if_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL store_gnt: got ls,if=%b expected 10", {ls_gnt, if_gnt});
    end
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, 4'b1100, 32'h8000_0100, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL store_mem: got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 1100 80000100 deadbeef",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({ls_rvalid, ls_err, if_rvalid, ls_rdata} !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("FAIL store_resp: got rv=%b err=%b if_rv=%b data=%h expected 1 0 0 00000000",
               ls_rvalid, ls_err, if_rvalid, ls_rdata);
    end
    $display("store addr=80000102 be=1100 wdata=deadbeef");
    @(negedge clk);
  endtask

  task automatic test_fault();
    // Load just below the window
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h7FFF_FFFC;
    #1;
    vectors++;
    if (ls_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_ls_gnt: got %b expected 1", ls_gnt);
    end
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    vectors++;
    if ({ls_rvalid, ls_err, mem_req, if_rvalid, ls_rdata} !== {4'b1100, 32'h0}) begin
      miscompares++;
      $display("FAIL fault_ls_resp: got rv=%b err=%b mreq=%b if_rv=%b data=%h expected 1 1 0 0 0",
               ls_rvalid, ls_err, mem_req, if_rvalid, ls_rdata);
    end
    $display("load addr=7fffFFFC faulted");
    @(negedge clk);
    // Fetch just past the window end
    if_req = 1'b1; if_addr = 32'h8080_0000;
    #1;
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_if_gnt: got %b expected 1", if_gnt);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    vectors++;
    if ({if_rvalid, if_err, mem_req, ls_rvalid, if_rdata} !== {4'b1100, 32'h0}) begin
      miscompares++;
      $display("FAIL fault_if_resp: got rv=%b err=%b mreq=%b ls_rv=%b data=%h expected 1 1 0 0 0",
               if_rvalid, if_err, mem_req, ls_rvalid, if_rdata);
    end
    $display("fetch addr=80800000 faulted");
    @(negedge clk);
    // Last word of the window is still valid
    if_req = 1'b1; if_addr = 32'h807F_FFFC;
    @(negedge clk);
    if_req = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h807F_FFFC}) begin
      miscompares++;
      $display("FAIL edge_in_range: got req=%b addr=%h expected 1 807ffffc", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0067;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'h67}) begin
      miscompares++;
      $display("FAIL edge_resp: got rv=%b err=%b data=%h expected 1 0 00000067", if_rvalid, if_err, if_rdata);
    end
    $display("fetch addr=807ffffc data=00000067");
    @(negedge clk);
  endtask

  task automatic test_timeout();
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h8000_0040;
    @(negedge clk);
    ls_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      vectors++;
      if ({mem_req, ls_rvalid} !== 2'b10) begin
        miscompares++;
        $display("FAIL timeout_wait[%0d]: got req=%b rv=%b expected 1 0", c, mem_req, ls_rvalid);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if ({mem_req, ls_rvalid, ls_err, ls_rdata} !== {3'b011, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_resp: got req=%b rv=%b err=%b data=%h expected 0 1 1 0",
               mem_req, ls_rvalid, ls_err, ls_rdata);
    end
    $display("load addr=80000040 timed out");
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({if_rvalid, ls_rvalid, mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL late_ack_ignored: got if_rv,ls_rv,req=%b expected 000", {if_rvalid, ls_rvalid, mem_req});
    end
    if_req = 1'b1; if_addr = 32'h8000_0008;
    #1;
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL post_timeout_gnt: got %b expected 1", if_gnt);
    end
    @(negedge clk);
    if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL post_timeout_resp: got rv=%b err=%b data=%h expected 1 0 00500093",
               if_rvalid, if_err, if_rdata);
    end
    $display("fetch addr=80000008 data=00500093 after timeout");
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h8000_0080;
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got mem_req=%b expected 1", mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_mem_req: got %b expected 0", mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({ls_rvalid, if_rvalid, mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_no_rvalid: got ls_rv,if_rv,req=%b expected 000", {ls_rvalid, if_rvalid, mem_req});
    end
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h8000_0000;
    ls_req = 1'b1; ls_addr = 32'h8000_00C0;
    #1;
    vectors++;
    if ({ls_gnt, if_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_then_conflict: got ls,if=%b expected 10", {ls_gnt, if_gnt});
    end
    $display("reset during wait, first conflict to LS");
    @(negedge clk);
    ls_req = 1'b0; if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_conflict();
    test_fetch();
    test_store();
    test_fault();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
